// File: rtl/frame_receiver_if.sv
// Byte link into the frame receiver and payload stream out of it.
// The slave modport is the receiver side; the master modport drives bytes
// into the receiver and consumes its payload stream.
interface frame_receiver_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_first;
  logic       out_last;
  logic [7:0] length_out;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  modport master (
    output in_data, in_valid,
    input  out_data, out_valid, out_first, out_last,
    input  length_out, frame_done, frame_err, busy
  );

  modport slave (
    input  in_data, in_valid,
    output out_data, out_valid, out_first, out_last,
    output length_out, frame_done, frame_err, busy
  );
endinterface

// File: rtl/frame_receiver.sv
// Receive-side parser for header/length/payload byte framing.
// Hunts for the header byte, captures the length byte, then streams out
// exactly that many payload bytes with first/last markers. Bad lengths and
// stalled frames raise a one-cycle error and return to header hunting.
module frame_receiver #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         MAX_LEN = 64,
  parameter int         TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              arst,
  frame_receiver_if.slave   bus
);

  typedef enum logic [1:0] {
    S_HUNT = 2'b00,
    S_LEN  = 2'b01,
    S_DATA = 2'b10
  } state_t;

  localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [7:0]  length_q, length_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] idle_q, idle_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  // The idle counter reaches its limit on the TIMEOUT-th consecutive idle
  // cycle; a valid byte that cycle clears it instead.
  assign timeout_hit = !bus.in_valid && (idle_q == IDLE_LIMIT);

  // Next-state and next-output decode for the framing FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    length_d    = length_q;
    data_d      = data_q;
    idle_d      = idle_q;
    valid_d     = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      S_HUNT: begin
        idle_d = '0;
        if (bus.in_valid && bus.in_data == HEADER) state_d = S_LEN;
      end

      S_LEN: begin
        if (bus.in_valid) begin
          idle_d = '0;
          if (bus.in_data == 8'd0 || bus.in_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else begin
            length_d    = bus.in_data;
            remaining_d = bus.in_data;
            state_d     = S_DATA;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          idle_d  = '0;
          state_d = S_HUNT;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end

      S_DATA: begin
        if (bus.in_valid) begin
          // Header-valued bytes here are payload; only the count ends a frame.
          idle_d      = '0;
          data_d      = bus.in_data;
          valid_d     = 1'b1;
          first_d     = (remaining_q == length_q);
          last_d      = (remaining_q == 8'd1);
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = S_HUNT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          idle_d  = '0;
          state_d = S_HUNT;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end

      default: begin
        // Unused encoding: fall back to hunting with clean counters.
        state_d     = S_HUNT;
        idle_d      = '0;
        remaining_d = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops any frame silently.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (arst) begin
      state_q     <= S_HUNT;
      remaining_q <= '0;
      length_q    <= '0;
      data_q      <= '0;
      idle_q      <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      length_q    <= length_d;
      data_q      <= data_d;
      idle_q      <= idle_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_first  = first_q;
  assign bus.out_last   = last_q;
  assign bus.frame_done = last_q;
  assign bus.frame_err  = err_q;
  assign bus.length_out = length_q;
  assign bus.busy       = (state_q == S_LEN) || (state_q == S_DATA);

endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: directed framing scenarios with
// literal expectations plus randomized traffic checked every cycle against
// a behavioural frame-parsing model.
module tb_frame_receiver;

  localparam logic [7:0] HEADER  = 8'hA5;
  localparam int         MAX_LEN = 64;
  localparam int         TIMEOUT = 255;

  logic clk;
  logic arst;

  frame_receiver_if bus ();

  frame_receiver #(
    .HEADER  (HEADER),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where we are in a frame, expressed as "bytes still
  // owed" rather than the design's state encoding.
  bit         m_in_frame;     // header seen
  bit         m_have_len;     // length accepted, payload expected
  int         m_len;
  int         m_emitted;
  int         m_idle;
  int         m_length_out;
  logic [7:0] m_data;
  bit e_valid, e_first, e_last, e_err;
  logic       s_valid, s_rst;
  logic [7:0] s_data;

  // Monitor record of what the DUT emitted: {first, last, data}.
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int err_cnt, done_cnt;

  // Per-cycle reference compare: update model from the bytes sampled at this
  // edge, then check the registered outputs shortly after.
  always @(posedge clk) begin
    s_valid = bus.in_valid;
    s_data  = bus.in_data;
    s_rst   = arst;
    e_valid = 0; e_first = 0; e_last = 0; e_err = 0;
    if (s_rst) begin
      m_in_frame = 0; m_have_len = 0; m_idle = 0;
      m_length_out = 0; m_data = 8'h00;
    end else if (s_valid) begin
      m_idle = 0;
      if (!m_in_frame) begin
        m_in_frame = (s_data == HEADER);
      end else if (!m_have_len) begin
        if (s_data == 0 || int'(s_data) > MAX_LEN) begin
          e_err = 1; m_in_frame = 0;
        end else begin
          m_len = int'(s_data); m_length_out = m_len;
          m_emitted = 0; m_have_len = 1;
        end
      end else begin
        e_valid = 1; m_data = s_data;
        e_first = (m_emitted == 0);
        m_emitted++;
        if (m_emitted == m_len) begin
          e_last = 1; m_in_frame = 0; m_have_len = 0;
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        e_err = 1; m_in_frame = 0; m_have_len = 0; m_idle = 0;
      end
    end
    #1;
    check("out_valid",  32'(bus.out_valid),  32'(e_valid));
    check("out_first",  32'(bus.out_first),  32'(e_first));
    check("out_last",   32'(bus.out_last),   32'(e_last));
    check("frame_done", 32'(bus.frame_done), 32'(e_last));
    check("frame_err",  32'(bus.frame_err),  32'(e_err));
    check("busy",       32'(bus.busy),       32'(m_in_frame));
    check("length_out", 32'(bus.length_out), 32'(m_length_out));
    if (e_valid) check("out_data", 32'(bus.out_data), 32'(m_data));
    if (bus.out_valid) got_q.push_back({bus.out_first, bus.out_last, bus.out_data});
    if (bus.frame_err) err_cnt++;
    if (bus.frame_done) done_cnt++;
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    err_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic check_got(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    arst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_valid",  32'(bus.out_valid),  32'd0);
    check("reset_busy",   32'(bus.busy),       32'd0);
    check("reset_length", 32'(bus.length_out), 32'd0);
    check("reset_data",   32'(bus.out_data),   32'd0);
    arst = 1'b0;
    clear_mon();

    // 1: continuous three-byte frame.
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    idle(3);
    exp_q = '{{2'b10, 8'h11}, {2'b00, 8'h22}, {2'b01, 8'h33}};
    check_got("t1");
    check("t1_done", 32'(done_cnt), 32'd1);
    check("t1_length", 32'(bus.length_out), 32'h03);
    clear_mon();

    // 2: leading junk, single-byte frame.
    send(8'h00); send(8'h7F); send(8'hA5); send(8'h01); send(8'h5A);
    idle(3);
    exp_q = '{{2'b11, 8'h5A}};
    check_got("t2");
    clear_mon();

    // 3: zero length and over-long length.
    send(8'hA5); send(8'h00); send(8'hA5); send(8'h41);
    idle(3);
    check("t3_err", 32'(err_cnt), 32'd2);
    check("t3_valid_count", 32'(got_q.size()), 32'd0);
    check("t3_busy", 32'(bus.busy), 32'd0);
    clear_mon();

    // 4: timeout on exactly the TIMEOUT-th idle cycle, then header as payload.
    send(8'hA5); send(8'h02); send(8'hAA);
    idle(TIMEOUT - 1);
    @(posedge clk); #2;
    check("t4_no_err_early", 32'(err_cnt), 32'd0);
    @(posedge clk); #2;
    check("t4_err_at_limit", 32'(err_cnt), 32'd1);
    send(8'hA5); send(8'h01); send(8'hA5);
    idle(3);
    exp_q = '{{2'b10, 8'hAA}, {2'b11, 8'hA5}};
    check_got("t4");
    check("t4_done", 32'(done_cnt), 32'd1);
    clear_mon();

    // 4b: a valid byte on the limit cycle beats the timeout.
    send(8'hA5); send(8'h02); send(8'hBB);
    idle(TIMEOUT - 1);
    send(8'hCC);
    idle(3);
    exp_q = '{{2'b10, 8'hBB}, {2'b01, 8'hCC}};
    check_got("t4b");
    check("t4b_err", 32'(err_cnt), 32'd0);
    clear_mon();

    // 5: reset mid-frame drops it silently.
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    @(negedge clk);
    arst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    check("t5_rst_valid",  32'(bus.out_valid),  32'd0);
    check("t5_rst_length", 32'(bus.length_out), 32'd0);
    check("t5_rst_busy",   32'(bus.busy),       32'd0);
    check("t5_rst_data",   32'(bus.out_data),   32'd0);
    send(8'hA5); send(8'h01); send(8'h77);
    idle(3);
    exp_q = '{{2'b10, 8'h01}, {2'b00, 8'h02}, {2'b11, 8'h77}};
    check_got("t5");
    check("t5_err", 32'(err_cnt), 32'd0);
    check("t5_done", 32'(done_cnt), 32'd1);
    clear_mon();

    // 6: two frames back-to-back with random gaps inside each frame.
    for (int f = 0; f < 2; f++) begin
      int len;
      len = int'($urandom_range(1, 16));
      send(HEADER);
      idle(int'($urandom_range(0, 4)));
      send(8'(len));
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        idle(int'($urandom_range(0, 4)));
        send(b);
        exp_q.push_back({(i == 0), (i == len - 1), b});
      end
    end
    idle(3);
    check_got("t6");
    check("t6_done", 32'(done_cnt), 32'd2);
    check("t6_err", 32'(err_cnt), 32'd0);
    clear_mon();

    // Random traffic: headers, good and bad lengths, gaps, stalls and resets.
    for (int n = 0; n < 2500; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      send(HEADER);
      else if (kind == 1) send(8'($urandom_range(0, 80)));
      else if (kind <= 5) send(8'($urandom));
      else if (kind <= 8) idle(int'($urandom_range(1, 3)));
      else if ($urandom_range(0, 19) == 0) idle(TIMEOUT + int'($urandom_range(0, 3)) - 2);
      else if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        arst = 1'b1;
        bus.in_valid = 1'($urandom);
        bus.in_data  = 8'($urandom);
        @(negedge clk);
        arst = 1'b0;
        bus.in_valid = 1'b0;
      end else idle(1);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
